// File: rtl/caliptra_prim_generic_pipe_buf.sv
// Elastic chain of Depth register stages with valid/ready handshake, bubble
// collapse, synchronous flush and occupancy reporting.
module caliptra_prim_generic_pipe_buf #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [Width-1:0]           in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [Width-1:0]           out_data_o,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic                       idle_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);

  if (Depth == 0 || Depth > 8) begin : gen_depth_check
    $error("caliptra_prim_generic_pipe_buf: Depth must be within 1..8");
  end

  logic [Depth-1:0]            valid_q, valid_d;
  logic [Depth-1:0][Width-1:0] data_q, data_d;
  logic [CntW-1:0]             count_q, count_d;
  logic [Depth-1:0]            adv;
  logic [Depth-1:0]            load;
  logic [Depth-1:0][Width-1:0] src;
  logic                        stage0_free;
  logic                        in_fire;
  logic                        out_fire;

  // Advance chain, resolved from the output end back towards stage 0.
  always_comb begin
    logic room;
    adv  = '0;
    room = out_ready_i;
    for (int k = int'(Depth) - 1; k >= 0; k--) begin
      adv[k] = valid_q[k] & room;
      room   = ~valid_q[k] | adv[k];
    end
    stage0_free = room;
  end

  assign in_ready_o = ~flush_i & stage0_free;
  assign in_fire    = in_valid_i & in_ready_o;
  assign out_fire   = adv[Depth-1];

  for (genvar k = 0; k < int'(Depth); k++) begin : gen_src
    if (k == 0) begin : gen_head
      assign load[k] = in_fire;
      assign src[k]  = in_data_i;
    end else begin : gen_body
      assign load[k] = adv[k-1];
      assign src[k]  = data_q[k-1];
    end
  end

  // A stage refills from its upstream neighbour whenever it is empty or draining.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int k = 0; k < int'(Depth); k++) begin
      if (flush_i) begin
        valid_d[k] = 1'b0;
      end else if (load[k]) begin
        valid_d[k] = 1'b1;
        data_d[k]  = src[k];
      end else if (adv[k]) begin
        valid_d[k] = 1'b0;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (in_fire && !out_fire) begin
      count_d = count_q + CntW'(1);
    end else if (!in_fire && out_fire) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  // Stale stage contents never leak onto the output bus.
  assign out_valid_o = valid_q[Depth-1];
  assign out_data_o  = valid_q[Depth-1] ? data_q[Depth-1] : '0;
  assign count_o     = count_q;
  assign idle_o      = (count_q == '0);

endmodule

// File: tb/tb_caliptra_prim_generic_pipe_buf.sv
// Drives one shared stimulus stream into Depth=1..4 buffers and checks each
// against a queue model of an elastic FIFO with a minimum transit of Depth cycles.
module tb_caliptra_prim_generic_pipe_buf;

  localparam int W = 32;
  localparam int NDUT = 4;

  typedef struct packed {
    logic [W-1:0] data;
    int           acc;
  } word_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b0;
  logic         chk_en = 1'b0;
  int           cyc = 0;
  int           n_vec = 0;
  int           n_mis = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int d, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s D=%0d cyc=%0d got=%h want=%h", tag, d, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : gen_dut
    localparam int D = g + 1;

    logic                     in_ready;
    logic                     out_valid;
    logic [W-1:0]             out_data;
    logic [$clog2(D+1)-1:0]   count;
    logic                     idle;

    caliptra_prim_generic_pipe_buf #(.Width(W), .Depth(D)) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (in_data),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .count_o     (count),
      .idle_o      (idle)
    );

    word_t        q[$];
    int           last_del = -1;
    logic         mv = 1'b0;
    logic         mr = 1'b0;
    logic [W-1:0] md = '0;

    // Head is visible once it has spent D cycles in flight and its predecessor has left.
    always @(negedge clk) begin
      mv = 1'b0;
      md = '0;
      if (q.size() != 0) begin
        if (cyc >= q[0].acc + D && cyc > last_del) begin
          mv = 1'b1;
          md = q[0].data;
        end
      end
      mr = !flush && (q.size() < D || out_ready);
      if (chk_en) begin
        check("out_valid", D, W'(out_valid), W'(mv));
        check("out_data",  D, out_data, md);
        check("count",     D, W'(count), W'(q.size()));
        check("idle",      D, W'(idle), W'(q.size() == 0));
        check("in_ready",  D, W'(in_ready), W'(mr));
      end
    end

    always @(posedge clk) begin
      if (rst) begin
        q.delete();
        last_del = -1;
      end else if (flush) begin
        q.delete();
      end else begin
        if (mv && out_ready) begin
          void'(q.pop_front());
          last_del = cyc;
        end
        if (in_valid && mr) q.push_back('{data: in_data, acc: cyc});
      end
    end
  end

  task automatic cyc_in(input logic r, input logic f, input logic v,
                        input logic [W-1:0] d, input logic o);
    rst = r; flush = f; in_valid = v; in_data = d; out_ready = o;
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    // Reset held for a second cycle, then released.
    cyc_in(1, 0, 0, '0, 0);
    cyc_in(0, 0, 0, '0, 1);

    // Streaming with no backpressure.
    cyc_in(0, 0, 1, 32'h11, 1);
    cyc_in(0, 0, 1, 32'h22, 1);
    cyc_in(0, 0, 1, 32'h33, 1);
    repeat (6) cyc_in(0, 0, 0, '0, 1);

    // Fill under a stalled output, then release.
    cyc_in(0, 0, 1, 32'h11, 0);
    cyc_in(0, 0, 1, 32'h22, 0);
    repeat (4) cyc_in(0, 0, 1, 32'h33, 0);
    cyc_in(0, 0, 1, 32'h33, 1);
    repeat (6) cyc_in(0, 0, 0, '0, 1);

    // Lone word travels to the last stage, then the rest fill behind it.
    cyc_in(0, 0, 1, 32'hA5, 0);
    repeat (6) cyc_in(0, 0, 0, '0, 0);
    cyc_in(0, 0, 1, 32'h01, 0);
    cyc_in(0, 0, 1, 32'h02, 0);
    cyc_in(0, 0, 1, 32'h03, 0);
    cyc_in(0, 0, 1, 32'h04, 0);

    // Flush while full with a word on offer, delivering the head the same cycle.
    cyc_in(0, 1, 1, 32'h77, 1);
    cyc_in(0, 0, 0, '0, 0);
    cyc_in(0, 0, 1, 32'h55, 0);
    cyc_in(0, 1, 1, 32'h66, 0);
    cyc_in(0, 0, 0, '0, 1);

    // Full and draining: simultaneous input and output transfers.
    repeat (5) cyc_in(0, 0, 1, $urandom, 0);
    repeat (8) cyc_in(0, 0, 1, $urandom, 1);

    // Random traffic with occasional flush and mid-stream reset.
    repeat (800) begin
      cyc_in(($urandom_range(0, 59) == 0), ($urandom_range(0, 31) == 0),
             ($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) != 0));
    end
    repeat (12) cyc_in(0, 0, 0, '0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
